uart_rx: RTL
============

// Module: uart_rx
// PURPOSE
//   Serial receiver for the system UART link: recovers 8N1 frames from the
//   external uart_rx line and presents bytes to the CPU-side I/O register.
//   Consumer-side valid/ready handshake with a one-byte holding buffer.
//   Pairs with the system's transmitter; uses the same bit timing (CLK_DIV).
// PARAMETERS
//   CLK_DIV    16  clk cycles per serial bit; legal range >= 4
//   DATA_BITS  8   data bits per frame, LSB first; legal range 5..8
// PORTS
//   clk        in   1          system clock; all logic on rising edge
//   rst        in   1          asynchronous, active-low reset (0 = reset)
//   rx         in   1          serial line, idle high; asynchronous to clk
//   data       out  DATA_BITS  received byte; valid only while valid=1
//   valid      out  1          holding buffer full
//   ready      in   1          consumer takes byte on a clk edge where valid&ready
//   frame_err  out  1          1-cycle pulse: stop bit sampled low
//   overrun    out  1          1-cycle pulse: frame completed while buffer full
//   parity_err out  1          1-cycle pulse: parity mismatch (0 unless macro)
// BEHAVIOUR
//   Reset (rst=0, async): state=IDLE, data=0, valid=0, all pulses 0,
//     synchroniser flops=1, bit/baud counters=0. Mid-frame reset drops frame.
//   rx passes a 2-flop synchroniser (rx_s); all decisions use rx_s.
//   Baud counter: reloads, counts down; a sample strobe fires when it hits 0.
//   FSM: IDLE, START, DATA, [PARITY], STOP.
//   - IDLE: falling edge of rx_s (prev 1, now 0) -> START, counter=CLK_DIV/2-1.
//     Line held low without a 1->0 edge never starts a frame.
//   - START: at strobe, rx_s=1 -> false start, back to IDLE, no pulses;
//     rx_s=0 -> DATA, counter=CLK_DIV-1, bit index=0.
//   - DATA: at each strobe shift rx_s in at bit index (LSB first); after
//     bit DATA_BITS-1 -> PARITY if compiled in, else STOP; counter=CLK_DIV-1.
//   - STOP: at strobe, rx_s=1 -> frame good; rx_s=0 -> frame_err pulse the
//     next cycle, byte discarded. Either way -> IDLE.
//   Buffer load: cycle after good stop sample, data<=shift reg, valid<=1.
//     Latency: valid rises 1 clk after stop-bit strobe (~2+CLK_DIV*(DATA_BITS+1.5) clk
//     after line start edge, incl. synchroniser).
//   Handshake: valid&ready on an edge -> valid<=0 next cycle. data is stable
//     while valid=1 and ready=0.
//   Simultaneous load and valid&ready: new byte loaded, valid stays 1, no overrun.
//   Load while valid=1 and ready=0: overrun pulse, new byte dropped, old kept.
//   Frame error and parity error never load the buffer and never raise overrun.
//   Back-to-back frames: IDLE re-arms the cycle after STOP; next start edge
//     at stop-bit end (no idle gap) must be accepted.
// CONFIGURATION
//   UART_RX_PARITY_EN defined: frame is 8E1; PARITY state samples one bit after
//     data; at stop, if stop=1 and XOR(data,parity)=1 -> parity_err pulse,
//     byte discarded; frame_err takes precedence when stop=0.
//   Undefined: no PARITY state, frame is 8N1, parity_err tied 0.
// TESTING
//   Byte 0xA5 at CLK_DIV=16, ready=1 -> valid pulses 1 cycle, data=0xA5,
//     no error pulses.
//   0x3C then 0xC3 back-to-back, ready=0 -> data=0x3C held, overrun pulse 1 cycle
//     at second frame end; after ready, valid=0; 0xC3 never visible.
//   Start glitch: rx low for 4 clk then high -> no valid, no pulses, FSM IDLE;
//     following 0x55 frame received correctly.
//   Frame 0x81 with stop bit forced 0 -> frame_err pulse, valid stays 0;
//     line held low 200 clk -> no further frames until rx returns high.
//   rst asserted mid-DATA of 0xFF, released, then 0x12 sent -> only 0x12 seen,
//     all outputs 0 during reset.
//   UART_RX_PARITY_EN: 0x07 with parity 1 -> data=0x07; with parity 0 ->
//     parity_err pulse, valid 0.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a one-byte valid/ready holding buffer.
// Define UART_RX_PARITY_EN to receive 8E1 frames and flag parity mismatches.
module uart_rx #(
    parameter int CLK_DIV   = 16,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 parity_err
);
    localparam int CW = $clog2(CLK_DIV);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] HALF = CW'(CLK_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(CLK_DIV - 1);
    localparam logic [IW-1:0] LAST = IW'(DATA_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t               state, state_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [IW-1:0]        idx, idx_n;
    logic [DATA_BITS-1:0] shreg;
    logic                 rx_m, rx_s, rx_p;
    logic                 strobe, stop_hit, good, bad_par, fall;

    assign strobe   = cnt == '0;
    assign stop_hit = state == STOP && strobe;
    assign fall     = rx_p && !rx_s;

`ifdef UART_RX_PARITY_EN
    localparam state_t AFTER_DATA = PARITY;
    logic par;
    assign bad_par = ^shreg ^ par;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par        <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            if (state == PARITY && strobe) par <= rx_s;
            parity_err <= stop_hit && rx_s && bad_par;
        end
    end
`else
    localparam state_t AFTER_DATA = STOP;
    assign bad_par    = 1'b0;
    assign parity_err = 1'b0;
`endif

    // A low stop bit outranks a parity mismatch, so good needs both.
    assign good = stop_hit && rx_s && !bad_par;

    always_comb begin
        state_n = state;
        cnt_n   = strobe ? FULL : cnt - 1'b1;
        idx_n   = idx;
        case (state)
            IDLE: begin
                cnt_n   = fall ? HALF : cnt;
                state_n = fall ? START : IDLE;
            end
            START: if (strobe) begin
                state_n = rx_s ? IDLE : DATA;
                idx_n   = '0;
            end
            DATA: if (strobe) begin
                idx_n   = idx + 1'b1;
                state_n = idx == LAST ? AFTER_DATA : DATA;
            end
            PARITY: if (strobe) state_n = STOP;
            STOP: if (strobe) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state              <= IDLE;
            cnt                <= '0;
            idx                <= '0;
            shreg              <= '0;
            {rx_m, rx_s, rx_p} <= 3'b111;
        end else begin
            state              <= state_n;
            cnt                <= cnt_n;
            idx                <= idx_n;
            {rx_p, rx_s, rx_m} <= {rx_s, rx_m, rx};
            if (state == DATA && strobe) shreg <= {rx_s, shreg[DATA_BITS-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= stop_hit && !rx_s;
            overrun   <= good && valid && !ready;
            if (good && (!valid || ready)) begin
                data  <= shreg;
                valid <= 1'b1;
            end else if (ready) begin
                valid <= 1'b0;
            end
        end
    end
endmodule
